// File: rtl/mux_scanner.sv
// mux_scanner: snapshots eight channels and serializes the enabled
// ones, lowest index first, onto a value/select valid/ready stream.
module mux_scanner #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [7:0]       mask_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] c_i,
    input  logic [Width-1:0] d_i,
    input  logic [Width-1:0] e_i,
    input  logic [Width-1:0] f_i,
    input  logic [Width-1:0] g_i,
    input  logic [Width-1:0] h_i,
    output logic [Width-1:0] value_o,
    output logic [2:0]       sel_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [Width-1:0] r_snap [8];
    logic [Width-1:0] w_live [8];
    logic [7:0]       r_mask;
    logic [7:0]       w_mask_nxt;
    logic [7:0]       w_rem;
    logic [2:0]       w_first;
    logic [2:0]       w_next;
    logic             w_snap_load;
    logic [Width-1:0] r_value;
    logic [Width-1:0] w_value_nxt;
    logic [2:0]       r_sel;
    logic [2:0]       w_sel_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;

    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        f_lowest = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) f_lowest = 3'(k);
        end
    endfunction

    assign w_live[0] = a_i;
    assign w_live[1] = b_i;
    assign w_live[2] = c_i;
    assign w_live[3] = d_i;
    assign w_live[4] = e_i;
    assign w_live[5] = f_i;
    assign w_live[6] = g_i;
    assign w_live[7] = h_i;

    // Remaining channels once the current one is accepted.
    assign w_rem   = r_mask & ~(8'd1 << r_sel);
    assign w_first = f_lowest(mask_i);
    assign w_next  = f_lowest(w_rem);

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_value_nxt = r_value;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_snap_load = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (start_i) begin
                    w_snap_load = 1'b1;
                    w_mask_nxt  = mask_i;
                    if (mask_i != 8'd0) begin
                        w_state_nxt = S_SEND;
                        w_sel_nxt   = w_first;
                        w_value_nxt = w_live[w_first];
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (ready_i) begin
                    w_mask_nxt = w_rem;
                    if (w_rem != 8'd0) begin
                        w_sel_nxt   = w_next;
                        w_value_nxt = r_snap[w_next];
                    end else begin
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, remaining mask and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_mask  <= 8'd0;
            r_value <= '0;
            r_sel   <= 3'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_value <= w_value_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Channel snapshot, captured only when a start is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 8; k++) r_snap[k] <= '0;
        end else if (w_snap_load) begin
            for (int k = 0; k < 8; k++) r_snap[k] <= w_live[k];
        end
    end

    assign value_o = r_value;
    assign sel_o   = r_sel;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: table-driven cycle vectors plus directed sequences
// for snapshot isolation and asynchronous reset mid-scan.
module tb_mux_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mask = 8'd0;
    logic [7:0] ch [8];
    logic [7:0] value;
    logic [2:0] sel;
    logic       valid;
    logic       ready = 1'b0;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_scanner #(.Width(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .mask_i  (mask),
        .a_i     (ch[0]),
        .b_i     (ch[1]),
        .c_i     (ch[2]),
        .d_i     (ch[3]),
        .e_i     (ch[4]),
        .f_i     (ch[5]),
        .g_i     (ch[6]),
        .h_i     (ch[7]),
        .value_o (value),
        .sel_o   (sel),
        .valid_o (valid),
        .ready_i (ready),
        .busy_o  (busy),
        .done_o  (done)
    );

    typedef struct {
        logic       start;
        logic [7:0] mask;
        logic       ready;
        logic       valid;
        logic [2:0] sel;
        logic [7:0] value;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic st, input logic [7:0] m, input logic rd,
        input logic v, input logic [2:0] s, input logic [7:0] val,
        input logic b, input logic d);
        vec_t t;
        t.start = st; t.mask = m; t.ready = rd;
        t.valid = v; t.sel = s; t.value = val;
        t.busy = b; t.done = d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic v,
                           input logic [2:0] s, input logic [7:0] val,
                           input logic b, input logic d);
        chk({nm, ".valid"}, 32'(valid), 32'(v));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".done"}, 32'(done), 32'(d));
        if (v) begin
            chk({nm, ".sel"}, 32'(sel), 32'(s));
            chk({nm, ".value"}, 32'(value), 32'(val));
        end
    endtask

    task automatic set_chan_default;
        for (int k = 0; k < 8; k++) ch[k] = 8'h10 + 8'(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_chan_default();

        // Full mask, ready=1, start pulse mid-scan, start on last
        // handshake, then back-to-back start in the DONE cycle.
        vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 8'h10, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 8'h11, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 2, 8'h12, 1, 0));
        vecs.push_back(mk(1, 8'h01, 1, 1, 3, 8'h13, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 4, 8'h14, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 5, 8'h15, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 6, 8'h16, 1, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 7, 8'h17, 1, 0));
        vecs.push_back(mk(1, 8'h00, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 8'h80, 0, 1, 7, 8'h17, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // Sparse mask with three stall cycles before each accept.
        vecs.push_back(mk(1, 8'hA4, 0, 1, 2, 8'h12, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 2, 8'h12, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 2, 8'h12, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 2, 8'h12, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 5, 8'h15, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 5, 8'h15, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 5, 8'h15, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 5, 8'h15, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 7, 8'h17, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 7, 8'h17, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 7, 8'h17, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 7, 8'h17, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // Empty mask: done without any item or busy.
        vecs.push_back(mk(1, 8'h00, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));

        // Reset state, sampled after a clock edge with reset held.
        tick();
        chk_all("reset", 0, 0, 8'h00, 0, 0);
        chk("reset.sel", 32'(sel), 32'd0);
        chk("reset.value", 32'(value), 32'd0);
        #5;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start = vecs[i].start;
            mask  = vecs[i].mask;
            ready = vecs[i].ready;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].sel,
                    vecs[i].value, vecs[i].busy, vecs[i].done);
        end

        // Snapshot isolation: live input change after start is ignored.
        ch[0] = 8'hAA;
        start = 1'b1; mask = 8'h01; ready = 1'b0;
        tick();
        start = 1'b0;
        chk_all("snap.first", 1, 0, 8'hAA, 1, 0);
        ch[0] = 8'h55;
        tick();
        chk_all("snap.hold", 1, 0, 8'hAA, 1, 0);
        ready = 1'b1;
        #2;
        chk("snap.xfer", 32'(value), 32'hAA);
        tick();
        chk_all("snap.done", 0, 0, 8'h00, 0, 1);
        ready = 1'b0;
        tick();
        set_chan_default();

        // Asynchronous reset between edges during SEND.
        start = 1'b1; mask = 8'hFF; ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("rst.pre", 1, 1, 8'h11, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async.valid", 32'(valid), 32'd0);
        chk("rst.async.busy", 32'(busy), 32'd0);
        chk("rst.async.sel", 32'(sel), 32'd0);
        chk("rst.async.value", 32'(value), 32'd0);
        chk("rst.async.done", 32'(done), 32'd0);
        tick();
        chk("rst.nodone", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;
        start = 1'b1; mask = 8'h06; ready = 1'b1;
        tick();
        start = 1'b0;
        chk_all("rst.after0", 1, 1, 8'h11, 1, 0);
        tick();
        chk_all("rst.after1", 1, 2, 8'h12, 1, 0);
        tick();
        chk_all("rst.after2", 0, 0, 8'h00, 0, 1);
        tick();
        chk_all("rst.after3", 0, 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scanner.md
# mux_scanner

Gathers eight parallel channel values and serializes them, lowest index first, onto one value/select stream with a valid/ready handshake. It is the collecting counterpart of the 1-to-8 value/select demultiplexer. Its `value_o`/`sel_o` stream carries the same pairs the demultiplexer consumes on `value_i`/`sel_i`, so the two blocks can be chained back to back in directed benches. A scan is started by a pulse and visits only the channels enabled in a mask.

## Interface
- `Width`, default 8: channel and value width in bits.

- `clk_i`  input  1  clock; all state changes on the rising edge.
- `rst_ni`  input  1  asynchronous, active-low reset.
- `start_i`  input  1  start a scan; sampled only while `busy_o`=0.
- `mask_i`  input  8  channel enable; bit k enables channel k (a=0 … h=7).
- `a_i` … `h_i`  input  Width each  channel values 0…7.
- `value_o`  output  Width  snapshot value of the current channel.
- `sel_o`  output  3  index of the current channel.
- `valid_o`  output  1  `value_o`/`sel_o` are valid.
- `ready_i`  input  1  downstream accepts the current item.
- `busy_o`  output  1  a scan is in progress.
- `done_o`  output  1  one-cycle pulse after a scan completes.

## Operation
- There are three states: IDLE, SEND and DONE.
- **IDLE.**
  - On the first edge with `start_i`=1, `a_i`…`h_i` and `mask_i` are snapshotted into internal registers. Live inputs are ignored from then on.
  - If `mask_i`≠0: go to SEND. `sel_o` = lowest set bit index, `value_o` = that channel's snapshot, `valid_o`=1, `busy_o`=1.
  - If `mask_i`=0: go to DONE. No item is emitted.
- **SEND.**
  - `value_o`, `sel_o` and `valid_o` hold stable while `ready_i`=0.
  - A handshake is `valid_o`&&`ready_i` at an edge. On a handshake, the current bit is cleared from the remaining mask.
  - If bits remain: load the next-lowest set index and its snapshot, and keep `valid_o`=1 with no bubble.
  - If no bits remain: `valid_o`=0, `busy_o`=0, `done_o`=1, go to DONE.
- **DONE.**
  - Lasts exactly one cycle, then goes to IDLE and `done_o` returns to 0.
  - `start_i` is accepted in DONE exactly as in IDLE, which allows back-to-back scans.
- `start_i` is ignored while `busy_o`=1, including a start coincident with the last handshake.
- The snapshot is held after a scan ends. `value_o` keeps its last value when `valid_o`=0; its content is not checked then.
- `sel_o` always equals an index whose bit was set in the snapshot mask. Indices are strictly increasing within a scan.

## Timing
- **Reset.** `rst_ni`=0 forces state IDLE immediately, without waiting for a clock edge. All outputs go to 0: `value_o`, `sel_o`, `valid_o`, `busy_o` and `done_o`. The snapshot and mask registers are also cleared.
  - Reset mid-scan abandons the scan with no `done_o`.
  - The first start is accepted on the first rising edge after `rst_ni` deasserts.
- **Start to first item.** A start sampled at edge N gives `valid_o`=1 from edge N, i.e. the first item is visible in cycle N+1.
- **Throughput.** With `ready_i` held at 1, one item is transferred per cycle. A scan with P enabled channels completes P cycles after start.
- **Done pulse.** `done_o` rises on the edge of the last handshake and is high for one cycle. `busy_o` falls on the same edge.
- **Empty mask.** `done_o` is high in the cycle after the start edge, with `busy_o` staying 0.
- **Registered outputs.** All outputs are registered; there is no combinational path from `ready_i` to any output.

## Test plan
- **Full mask, continuous ready.** `mask_i`=8'hFF, `a_i`…`h_i`=8'h10…8'h17, `ready_i`=1 → 8 items: `sel_o` 0…7 with `value_o` 8'h10…8'h17 on consecutive cycles. `done_o` pulses once, 8 cycles after start.
- **Sparse mask with backpressure.** `mask_i`=8'b1010_0100, `ready_i` low for 3 cycles before each accept → items (2,c), (5,f), (7,h). Each item stays stable for all 4 cycles it is held. There is exactly one `done_o`.
- **Snapshot isolation.** Start with `a_i`=8'hAA, mask 8'h01, `ready_i`=0. Change `a_i` to 8'h55, then raise `ready_i` → the transferred value is 8'hAA.
- **Empty mask.** `mask_i`=0 with a `start_i` pulse → `valid_o` never rises, `busy_o` stays 0, `done_o`=1 in the cycle after start.
- **Start while busy and back-to-back.** Pulse `start_i` mid-scan → it is ignored and the item order is unchanged. Assert `start_i` in the DONE cycle with mask 8'h80 → (7,h) is valid in the next cycle.
- **Reset mid-scan.** Drive `rst_ni`=0 between clock edges during SEND → all outputs go to 0 immediately and no `done_o` is produced. A new start after release scans normally.
